// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: opcodes, ALU op encodings, control bit indices
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 10;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Bit positions inside id_ex_ctrl; the EX stage indexes with the same names.
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_OP_HI  = 2;
    localparam int CTRL_ALU_OP_LO  = 1;
    localparam int CTRL_ILLEGAL    = 0;

    // Main control decoder: opcode -> control word. Unknown opcodes only raise illegal.
    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (op)
            OP_R: begin
                c[CTRL_REG_WRITE] = 1'b1;
                c[CTRL_REG_DST]   = 1'b1;
                c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_FUNCT;
            end
            OP_LW: begin
                c[CTRL_REG_WRITE]  = 1'b1;
                c[CTRL_MEM_TO_REG] = 1'b1;
                c[CTRL_MEM_READ]   = 1'b1;
                c[CTRL_ALU_SRC]    = 1'b1;
                c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_ADD;
            end
            OP_SW: begin
                c[CTRL_MEM_WRITE] = 1'b1;
                c[CTRL_ALU_SRC]   = 1'b1;
                c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_ADD;
            end
            OP_BEQ: begin
                c[CTRL_BRANCH] = 1'b1;
                c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_SUB;
            end
            OP_ADDI: begin
                c[CTRL_REG_WRITE] = 1'b1;
                c[CTRL_ALU_SRC]   = 1'b1;
                c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_ADD;
            end
            default: c[CTRL_ILLEGAL] = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with r0 hardwired to zero and write bypass
module regfile_2r1w
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && (waddr != '0);

    // Storage update; r0 is never written so its entry stays zero from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: r0 reads zero, a same-cycle write is forwarded ahead of storage.
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (wr_en && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (wr_en && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode: control decode, regfile read, load-use hazard, ID/EX register
module id_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_id_instr,
    input  logic [XLEN-1:0]   if_id_npc,
    input  logic              if_id_valid,
    input  logic              ex_mem_pcsrc,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [XLEN-1:0]   wb_write_data,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [XLEN-1:0]   id_ex_npc,
    output logic [XLEN-1:0]   id_ex_rs_data,
    output logic [XLEN-1:0]   id_ex_rt_data,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [REG_AW-1:0] id_ex_rs,
    output logic [REG_AW-1:0] id_ex_rt,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic [CTRL_W-1:0] id_ex_ctrl
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic              uses_rt;
    logic              load_use;
    logic              bubble;

    assign opcode = if_id_instr[31:26];
    assign rs     = if_id_instr[25:21];
    assign rt     = if_id_instr[20:16];
    assign rd     = if_id_instr[15:11];
    assign imm    = {{(XLEN-16){if_id_instr[15]}}, if_id_instr[15:0]};
    assign ctrl   = decode_ctrl(opcode);

    regfile_2r1w u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_data),
        .rdata_b (rt_data),
        .we      (wb_reg_write),
        .waddr   (wb_write_reg),
        .wdata   (wb_write_data)
    );

    // Load-use hazard: the load in ID/EX produces a register the current instruction reads.
    // rt is only a source for R-type, SW and BEQ; for LW/ADDI it is the destination.
    always_comb begin
        uses_rt  = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
        load_use = id_ex_valid && id_ex_ctrl[CTRL_MEM_READ] && (id_ex_rt != '0) && if_id_valid &&
                   ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));
        // A taken branch discards the instruction anyway, so holding fetch would be wrong.
        stall    = load_use && !ex_mem_pcsrc;
        bubble   = ex_mem_pcsrc || load_use;
    end

    // ID/EX pipeline register; flush and stall both insert a bubble (valid=0, ctrl=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid   <= 1'b0;
            id_ex_npc     <= '0;
            id_ex_rs_data <= '0;
            id_ex_rt_data <= '0;
            id_ex_imm     <= '0;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_rd      <= '0;
            id_ex_ctrl    <= '0;
        end else begin
            id_ex_npc     <= if_id_npc;
            id_ex_rs_data <= rs_data;
            id_ex_rt_data <= rt_data;
            id_ex_imm     <= imm;
            id_ex_rs      <= rs;
            id_ex_rt      <= rt;
            id_ex_rd      <= rd;
            if (bubble) begin
                id_ex_valid <= 1'b0;
                id_ex_ctrl  <= '0;
            end else begin
                id_ex_valid <= if_id_valid;
                id_ex_ctrl  <= ctrl;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed scoreboard bench for id_stage
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        ex_mem_pcsrc;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        stall;
    logic        id_ex_valid;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rs_data;
    logic [31:0] id_ex_rt_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [9:0]  id_ex_ctrl;

    localparam logic [9:0] C_R    = 10'h20C;
    localparam logic [9:0] C_LW   = 10'h390;
    localparam logic [9:0] C_SW   = 10'h050;
    localparam logic [9:0] C_BEQ  = 10'h022;
    localparam logic [9:0] C_ADDI = 10'h210;
    localparam logic [9:0] C_ILL  = 10'h001;

    // mode 0: bubble (valid/ctrl), 1: full compare, 2: valid only
    typedef struct {
        int          mode;
        logic        valid;
        logic [9:0]  ctrl;
        logic [31:0] npc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    id_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_id_instr   (if_id_instr),
        .if_id_npc     (if_id_npc),
        .if_id_valid   (if_id_valid),
        .ex_mem_pcsrc  (ex_mem_pcsrc),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .stall         (stall),
        .id_ex_valid   (id_ex_valid),
        .id_ex_npc     (id_ex_npc),
        .id_ex_rs_data (id_ex_rs_data),
        .id_ex_rt_data (id_ex_rt_data),
        .id_ex_imm     (id_ex_imm),
        .id_ex_rs      (id_ex_rs),
        .id_ex_rt      (id_ex_rt),
        .id_ex_rd      (id_ex_rd),
        .id_ex_ctrl    (id_ex_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic set_if(input logic [31:0] instr, input logic [31:0] npc, input logic v);
        if_id_instr = instr;
        if_id_npc   = npc;
        if_id_valid = v;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write  = en;
        wb_write_reg  = r;
        wb_write_data = d;
    endtask

    task automatic push_full(input logic [9:0] c, input logic [31:0] rsd, input logic [31:0] rtd);
        exp_t e;
        e.mode    = 1;
        e.valid   = 1'b1;
        e.ctrl    = c;
        e.npc     = if_id_npc;
        e.rs_data = rsd;
        e.rt_data = rtd;
        e.imm     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        e.rs      = if_id_instr[25:21];
        e.rt      = if_id_instr[20:16];
        e.rd      = if_id_instr[15:11];
        exp_q.push_back(e);
    endtask

    task automatic push_simple(input int mode, input logic v);
        exp_t e;
        e = '{mode: mode, valid: v, ctrl: 10'd0, npc: 32'd0, rs_data: 32'd0, rt_data: 32'd0,
              imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        exp_q.push_back(e);
    endtask

    // Advance one edge and compare the oldest expectation with the ID/EX outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("id_ex_valid", 32'(id_ex_valid), 32'(e.valid));
            if (e.mode != 2) chk("id_ex_ctrl", 32'(id_ex_ctrl), 32'(e.ctrl));
            if (e.mode == 1) begin
                chk("id_ex_npc", id_ex_npc, e.npc);
                chk("id_ex_rs_data", id_ex_rs_data, e.rs_data);
                chk("id_ex_rt_data", id_ex_rt_data, e.rt_data);
                chk("id_ex_imm", id_ex_imm, e.imm);
                chk("id_ex_rs", 32'(id_ex_rs), 32'(e.rs));
                chk("id_ex_rt", 32'(id_ex_rt), 32'(e.rt));
                chk("id_ex_rd", 32'(id_ex_rd), 32'(e.rd));
            end
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_valid"}, 32'(id_ex_valid), 32'd0);
        chk({pfx, "_npc"}, id_ex_npc, 32'd0);
        chk({pfx, "_rs_data"}, id_ex_rs_data, 32'd0);
        chk({pfx, "_rt_data"}, id_ex_rt_data, 32'd0);
        chk({pfx, "_imm"}, id_ex_imm, 32'd0);
        chk({pfx, "_rs"}, 32'(id_ex_rs), 32'd0);
        chk({pfx, "_rt"}, 32'(id_ex_rt), 32'd0);
        chk({pfx, "_rd"}, 32'(id_ex_rd), 32'd0);
        chk({pfx, "_ctrl"}, 32'(id_ex_ctrl), 32'd0);
        chk({pfx, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        ex_mem_pcsrc = 1'b0;
        set_if(32'd0, 32'd0, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // WB r5 while decoding add r1,r5,r0 in the same cycle: bypass
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        set_if(r_ins(5'd5, 5'd0, 5'd1), 32'h100, 1'b1);
        push_full(C_R, 32'hDEADBEEF, 32'd0);
        tick();

        // r0 write is discarded, also not bypassed; then write r4
        set_wb(1'b1, 5'd0, 32'h1234);
        set_if(r_ins(5'd0, 5'd5, 5'd6), 32'h104, 1'b1);
        push_full(C_R, 32'd0, 32'hDEADBEEF);
        tick();
        set_wb(1'b1, 5'd4, 32'h44);
        push_full(C_R, 32'd0, 32'hDEADBEEF);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);

        // Load-use: lw r2,4(r1); add r3,r2,r4
        set_if(i_ins(6'h23, 5'd1, 5'd2, 16'd4), 32'h200, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(r_ins(5'd2, 5'd4, 5'd3), 32'h204, 1'b1);
        #1;
        chk("loaduse_stall", 32'(stall), 32'd1);
        push_simple(0, 1'b0);
        tick();
        chk("loaduse_stall_release", 32'(stall), 32'd0);
        push_full(C_R, 32'd0, 32'h44);
        tick();

        // lw r2 then addi r2,r1,1: rt is a destination, no stall
        set_if(i_ins(6'h23, 5'd1, 5'd2, 16'd4), 32'h300, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(i_ins(6'h08, 5'd1, 5'd2, 16'd1), 32'h304, 1'b1);
        #1;
        chk("addi_rt_nostall", 32'(stall), 32'd0);
        push_full(C_ADDI, 32'd0, 32'd0);
        tick();

        // lw r2 then sw r2,-4(r9): rt is a source, stall
        set_if(i_ins(6'h23, 5'd1, 5'd2, 16'd4), 32'h400, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(i_ins(6'h2B, 5'd9, 5'd2, 16'hFFFC), 32'h404, 1'b1);
        #1;
        chk("sw_rt_stall", 32'(stall), 32'd1);
        push_simple(0, 1'b0);
        tick();
        push_full(C_SW, 32'd0, 32'd0);
        tick();

        // lw r2 then beq r1,r2 with if_id_valid=0: no stall; then valid beq decodes
        set_if(i_ins(6'h23, 5'd1, 5'd2, 16'd4), 32'h500, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(i_ins(6'h04, 5'd1, 5'd2, 16'h0010), 32'h504, 1'b0);
        #1;
        chk("invalid_nostall", 32'(stall), 32'd0);
        push_simple(2, 1'b0);
        tick();
        set_if(i_ins(6'h04, 5'd1, 5'd2, 16'h0010), 32'h508, 1'b1);
        push_full(C_BEQ, 32'd0, 32'd0);
        tick();

        // lw r0: destination r0 never creates a hazard
        set_if(i_ins(6'h23, 5'd1, 5'd0, 16'd8), 32'h600, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(r_ins(5'd0, 5'd4, 5'd3), 32'h604, 1'b1);
        #1;
        chk("rt0_nostall", 32'(stall), 32'd0);
        push_full(C_R, 32'd0, 32'h44);
        tick();

        // Flush during load-use stall
        set_if(i_ins(6'h23, 5'd1, 5'd2, 16'd4), 32'h700, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(r_ins(5'd2, 5'd4, 5'd3), 32'h704, 1'b1);
        ex_mem_pcsrc = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        push_simple(0, 1'b0);
        tick();
        ex_mem_pcsrc = 1'b0;
        set_if(i_ins(6'h08, 5'd5, 5'd7, 16'd5), 32'h800, 1'b1);
        push_full(C_ADDI, 32'hDEADBEEF, 32'd0);
        tick();

        // Illegal opcode 0x3F, negative immediate
        set_if(i_ins(6'h3F, 5'd0, 5'd0, 16'h8000), 32'h804, 1'b1);
        push_full(C_ILL, 32'd0, 32'd0);
        tick();
        chk("illegal_imm", id_ex_imm, 32'hFFFF8000);

        // Reset mid-stall clears outputs, stall and regfile
        set_if(i_ins(6'h23, 5'd1, 5'd2, 16'd4), 32'h900, 1'b1);
        push_full(C_LW, 32'd0, 32'd0);
        tick();
        set_if(r_ins(5'd2, 5'd4, 5'd3), 32'h904, 1'b1);
        #1;
        chk("midrun_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_stall", 32'(stall), 32'd0);
        push_full(C_R, 32'd0, 32'd0);
        tick();
        set_if(r_ins(5'd5, 5'd0, 5'd1), 32'hA00, 1'b1);
        push_full(C_R, 32'd0, 32'd0);
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
